beatmap_scheduler: RTL and testbench

Sequences the per-lane beatmap data generators of the rhythm game from a single beat clock. A beat divider counts out the beat period, and on each beat the block snapshots which lanes have a note due. It then serves those lanes round-robin onto one note stream (valid/ready) toward the note-spawn/render logic, and pulses the served lane's step enable so that lane's generator advances to its next position.

---
 rtl/beatmap_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_beatmap_scheduler.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/beatmap_scheduler.sv
// rtl/beatmap_scheduler.sv - beat divider with per-beat lane snapshot served round-robin onto one note stream
module beatmap_scheduler #(
    parameter int NUM_LANES  = 4,
    parameter int LANE_W     = 2,
    parameter int BEAT_DIV   = 12500000,
    parameter int SONG_BEATS = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   pause,
    input  logic [NUM_LANES-1:0]   lane_req,
    input  logic [NUM_LANES*8-1:0] lane_data,
    output logic [NUM_LANES-1:0]   lane_step,
    output logic                   note_valid,
    input  logic                   note_ready,
    output logic [LANE_W-1:0]      note_lane,
    output logic [7:0]             note_pos,
    output logic                   beat_tick,
    output logic [7:0]             beat_count,
    output logic [7:0]             drop_cnt,
    output logic [1:0]             state,
    output logic                   song_done
);

    localparam int DIV_W = $clog2(BEAT_DIV);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [DIV_W-1:0]       div_cnt_q, div_cnt_d;
    logic                   beat_tick_q, beat_tick_d;
    logic [7:0]             beat_count_q, beat_count_d;
    logic [7:0]             drop_cnt_q, drop_cnt_d;
    logic [NUM_LANES-1:0]   pending_q, pending_d;
    logic [LANE_W-1:0]      last_grant_q, last_grant_d;
    logic                   note_valid_q, note_valid_d;
    logic [LANE_W-1:0]      note_lane_q, note_lane_d;
    logic [7:0]             note_pos_q, note_pos_d;
    logic [NUM_LANES-1:0]   lane_step_q, lane_step_d;

    logic                   grant_found;
    logic [LANE_W-1:0]      grant_lane;
    logic [LANE_W-1:0]      cand;
    logic                   slot_free, accept, issue, song_over, beat_edge;
    logic [NUM_LANES-1:0]   drop_mask;
    logic [LANE_W:0]        drop_add;
    logic [8:0]             drop_sum;

    // Round-robin search starts just after the last lane served.
    always_comb begin
        grant_found = 1'b0;
        grant_lane  = '0;
        cand        = '0;
        for (int i = 1; i <= NUM_LANES; i++) begin
            cand = LANE_W'((int'(last_grant_q) + i) % NUM_LANES);
            if (!grant_found && pending_q[cand]) begin
                grant_found = 1'b1;
                grant_lane  = cand;
            end
        end
    end

    assign slot_free = !note_valid_q || note_ready;
    assign accept    = note_valid_q && note_ready;
    assign issue     = (state_q == S_RUN) && !pause && grant_found && slot_free;
    assign song_over = (beat_count_q == 8'(SONG_BEATS));
    assign beat_edge = (div_cnt_q == DIV_W'(BEAT_DIV - 1));

    // Lanes still pending at a beat (after this edge's grant) are lost.
    always_comb begin
        drop_mask = pending_q & ~(issue ? (NUM_LANES'(1) << grant_lane) : '0);
        drop_add  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            drop_add = drop_add + {{LANE_W{1'b0}}, drop_mask[i]};
        end
        drop_sum = {1'b0, drop_cnt_q} + {{(8 - LANE_W){1'b0}}, drop_add};
    end

    always_comb begin
        state_d      = state_q;
        div_cnt_d    = div_cnt_q;
        beat_tick_d  = 1'b0;
        beat_count_d = beat_count_q;
        drop_cnt_d   = drop_cnt_q;
        pending_d    = pending_q;
        last_grant_d = last_grant_q;
        note_valid_d = note_valid_q;
        note_lane_d  = note_lane_q;
        note_pos_d   = note_pos_q;
        lane_step_d  = '0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_RUN;
                    div_cnt_d    = '0;
                    beat_count_d = '0;
                    drop_cnt_d   = '0;
                    pending_d    = '0;
                    last_grant_d = LAST_LANE;
                end
            end
            S_RUN: begin
                if (accept) note_valid_d = 1'b0;
                if (pause) begin
                    state_d = S_PAUSED;
                end else begin
                    if (issue) begin
                        note_valid_d            = 1'b1;
                        note_lane_d             = grant_lane;
                        note_pos_d              = lane_data[int'(grant_lane)*8 +: 8];
                        lane_step_d             = NUM_LANES'(1) << grant_lane;
                        pending_d[grant_lane]   = 1'b0;
                        last_grant_d            = grant_lane;
                    end
                    if (!song_over) begin
                        if (beat_edge) begin
                            div_cnt_d    = '0;
                            beat_tick_d  = 1'b1;
                            beat_count_d = beat_count_q + 8'd1;
                            drop_cnt_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
                            pending_d    = lane_req;
                        end else begin
                            div_cnt_d = div_cnt_q + DIV_W'(1);
                        end
                    end else if (pending_q == '0 && !note_valid_q) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_PAUSED: begin
                if (accept) note_valid_d = 1'b0;
                if (!pause) state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            div_cnt_q    <= '0;
            beat_tick_q  <= 1'b0;
            beat_count_q <= '0;
            drop_cnt_q   <= '0;
            pending_q    <= '0;
            last_grant_q <= LAST_LANE;
            note_valid_q <= 1'b0;
            note_lane_q  <= '0;
            note_pos_q   <= '0;
            lane_step_q  <= '0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            beat_tick_q  <= beat_tick_d;
            beat_count_q <= beat_count_d;
            drop_cnt_q   <= drop_cnt_d;
            pending_q    <= pending_d;
            last_grant_q <= last_grant_d;
            note_valid_q <= note_valid_d;
            note_lane_q  <= note_lane_d;
            note_pos_q   <= note_pos_d;
            lane_step_q  <= lane_step_d;
        end
    end

    assign lane_step  = lane_step_q;
    assign note_valid = note_valid_q;
    assign note_lane  = note_lane_q;
    assign note_pos   = note_pos_q;
    assign beat_tick  = beat_tick_q;
    assign beat_count = beat_count_q;
    assign drop_cnt   = drop_cnt_q;
    assign state      = state_q;
    assign song_done  = (state_q == S_DONE);

endmodule

// File: tb/tb_beatmap_scheduler.sv
// tb/tb_beatmap_scheduler.sv - randomized scoreboard bench for beatmap_scheduler
module tb_beatmap_scheduler;

    localparam int NL = 4;
    localparam int LW = 2;
    localparam int BD = 8;
    localparam int SB = 120;

    logic            clk = 1'b0;
    logic            reset, start, pause, note_ready;
    logic [NL-1:0]   lane_req;
    logic [NL*8-1:0] lane_data;
    logic [NL-1:0]   lane_step;
    logic            note_valid;
    logic [LW-1:0]   note_lane;
    logic [7:0]      note_pos;
    logic            beat_tick;
    logic [7:0]      beat_count;
    logic [7:0]      drop_cnt;
    logic [1:0]      state;
    logic            song_done;

    always #5 clk = ~clk;

    beatmap_scheduler #(
        .NUM_LANES (NL),
        .LANE_W    (LW),
        .BEAT_DIV  (BD),
        .SONG_BEATS(SB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pause     (pause),
        .lane_req  (lane_req),
        .lane_data (lane_data),
        .lane_step (lane_step),
        .note_valid(note_valid),
        .note_ready(note_ready),
        .note_lane (note_lane),
        .note_pos  (note_pos),
        .beat_tick (beat_tick),
        .beat_count(beat_count),
        .drop_cnt  (drop_cnt),
        .state     (state),
        .song_done (song_done)
    );

    int checks   = 0;
    int failures = 0;

    int exp_lane_q[$];
    int exp_pos_q[$];

    // Reference model: values describe the DUT state that is current after the next clock edge.
    int          m_state, m_div, m_beats, m_drop, m_last, m_step;
    bit          m_tick, m_holding;
    bit [NL-1:0] m_pend;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_state = 0; m_div = 0; m_beats = 0; m_drop = 0;
        m_last = NL - 1; m_step = -1; m_tick = 0; m_holding = 0; m_pend = '0;
        exp_lane_q.delete();
        exp_pos_q.delete();
    endfunction

    function automatic void model_step(bit st, bit ps, bit [NL-1:0] req, bit [NL*8-1:0] data, bit rdy);
        bit          accepted;
        bit          had_note;
        bit [NL-1:0] old_pend;
        int          g;
        int          lane;
        accepted = m_holding && rdy;
        had_note = m_holding;
        old_pend = m_pend;
        m_tick = 0;
        m_step = -1;
        case (m_state)
            0, 3: begin
                if (st) begin
                    m_state = 1; m_div = 0; m_beats = 0; m_drop = 0;
                    m_pend = '0; m_last = NL - 1;
                end
            end
            1: begin
                if (accepted) m_holding = 0;
                if (ps) begin
                    m_state = 2;
                end else begin
                    if (m_pend != 0 && !m_holding) begin
                        g = -1;
                        for (int k = 1; k <= NL; k++) begin
                            lane = (m_last + k) % NL;
                            if (g < 0 && m_pend[lane]) g = lane;
                        end
                        m_holding = 1;
                        m_step = g;
                        m_pend[g] = 1'b0;
                        m_last = g;
                        exp_lane_q.push_back(g);
                        exp_pos_q.push_back(int'(data[8*g +: 8]));
                    end
                    if (m_beats < SB) begin
                        if (m_div == BD - 1) begin
                            m_div = 0;
                            m_tick = 1;
                            m_beats++;
                            m_drop = m_drop + $countones(m_pend);
                            if (m_drop > 255) m_drop = 255;
                            m_pend = req;
                        end else begin
                            m_div++;
                        end
                    end else if (old_pend == 0 && !had_note) begin
                        m_state = 3;
                    end
                end
            end
            default: begin
                if (accepted) m_holding = 0;
                if (!ps) m_state = 1;
            end
        endcase
    endfunction

    task automatic cyc(input bit rst, input bit st, input bit ps, input bit [NL-1:0] req,
                       input bit [NL*8-1:0] data, input bit rdy);
        @(posedge clk);
        #1;
        reset = rst; start = st; pause = ps;
        lane_req = req; lane_data = data; note_ready = rdy;
        if (rst) begin
            model_reset();
            #1;
            check("rst_note_valid", int'(note_valid), 0);
            check("rst_lane_step", int'(lane_step), 0);
            check("rst_state", int'(state), 0);
            check("rst_beat_count", int'(beat_count), 0);
        end
        @(negedge clk);
        check("state", int'(state), m_state);
        check("beat_tick", int'(beat_tick), int'(m_tick));
        check("beat_count", int'(beat_count), m_beats);
        check("drop_cnt", int'(drop_cnt), m_drop);
        check("note_valid", int'(note_valid), int'(m_holding));
        check("lane_step", int'(lane_step), (m_step < 0) ? 0 : (1 << m_step));
        check("song_done", int'(song_done), (m_state == 3) ? 1 : 0);
        if (!rst) model_step(st, ps, req, data, rdy);
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0 && note_valid === 1'b1 && note_ready === 1'b1) begin
            if (exp_lane_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL note_unexpected: got lane %0d pos %0d expected no note at %0t",
                         note_lane, note_pos, $time);
            end else begin
                check("note_lane", int'(note_lane), exp_lane_q.pop_front());
                check("note_pos", int'(note_pos), exp_pos_q.pop_front());
            end
        end
    end

    initial begin
        bit [NL*8-1:0] data0;
        bit            rnd_pause;
        reset = 1'b1; start = 1'b0; pause = 1'b0; note_ready = 1'b0;
        lane_req = '0; lane_data = '0;
        model_reset();
        data0 = {8'd192, 8'd188, 8'd184, 8'd180};

        repeat (2) cyc(1, 0, 0, '0, '0, 0);
        repeat (3) cyc(0, 0, 0, 4'b1011, data0, 1);

        cyc(0, 1, 0, 4'b1011, data0, 1);
        repeat (20) cyc(0, 0, 0, 4'b1011, data0, 1);

        repeat (12) cyc(0, 0, 0, 4'b1011, data0, 0);
        repeat (20) cyc(0, 0, 0, 4'b1011, data0, 1);

        for (int i = 0; i < 20 && m_div != 5; i++) cyc(0, 0, 0, 4'b0110, data0, 1);
        repeat (20) cyc(0, 0, 1, 4'b0110, data0, 1);
        repeat (12) cyc(0, 0, 0, 4'b0110, data0, 1);

        for (int i = 0; i < 1100 && m_drop < 255; i++) cyc(0, 0, 0, 4'hF, $urandom, 0);
        repeat (30) cyc(0, 0, 0, 4'hF, $urandom, 0);

        for (int i = 0; i < 1500 && m_state != 3; i++)
            cyc(0, 0, ($urandom_range(0, 19) == 0), NL'($urandom), $urandom, 1);
        repeat (5) cyc(0, 0, 1, 4'hF, $urandom, 1);

        cyc(0, 1, 0, 4'b1011, data0, 1);
        repeat (20) cyc(0, 0, 0, 4'b1101, $urandom, 1);

        rnd_pause = 0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 29) == 0) rnd_pause = !rnd_pause;
            cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 59) == 0), rnd_pause,
                NL'($urandom), $urandom, ($urandom_range(0, 9) < 7));
        end

        cyc(0, 1, 0, 4'hF, $urandom, 0);
        repeat (12) cyc(0, 0, 0, 4'hF, $urandom, 0);
        cyc(1, 0, 0, 4'hF, $urandom, 1);
        repeat (3) cyc(0, 0, 0, 4'hF, $urandom, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
